// File: rtl/axi4_lite_regfile_slave.sv
// AXI4-Lite subordinate exposing NUM_REGS 32-bit read/write registers.
// Optional build macro AXI4_LITE_REGFILE_ERR_EN: illegal addresses answer SLVERR.
module axi4_lite_regfile_slave #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_REGS      = 16
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  input  logic [ADDRESS_WIDTH-1:0]  S_AWADDR,
  input  logic                      S_AWVALID,
  output logic                      S_AWREADY,
  input  logic [DATA_WIDTH-1:0]     S_WDATA,
  input  logic [DATA_WIDTH/8-1:0]   S_WSTRB,
  input  logic                      S_WVALID,
  output logic                      S_WREADY,
  output logic [1:0]                S_BRESP,
  output logic                      S_BVALID,
  input  logic                      S_BREADY,
  input  logic [ADDRESS_WIDTH-1:0]  S_ARADDR,
  input  logic                      S_ARVALID,
  output logic                      S_ARREADY,
  output logic [DATA_WIDTH-1:0]     S_RDATA,
  output logic [1:0]                S_RRESP,
  output logic                      S_RVALID,
  input  logic                      S_RREADY
);

  localparam int IDXW = $clog2(NUM_REGS);
  localparam int NSTRB = DATA_WIDTH / 8;
  localparam logic [ADDRESS_WIDTH-1:0] LIMIT =
    ADDRESS_WIDTH'(NUM_REGS * 4);
  localparam logic [1:0] OKAY = 2'b00;
`ifdef AXI4_LITE_REGFILE_ERR_EN
  localparam logic [1:0] BAD_RESP = 2'b10;
`else
  localparam logic [1:0] BAD_RESP = 2'b00;
`endif

  logic [DATA_WIDTH-1:0]    r_regs [NUM_REGS];
  logic                     r_aw_full;
  logic [ADDRESS_WIDTH-1:0] r_aw_addr;
  logic                     r_w_full;
  logic [DATA_WIDTH-1:0]    r_w_data;
  logic [NSTRB-1:0]         r_w_strb;
  logic                     r_bvalid;
  logic [1:0]               r_bresp;
  logic                     r_rvalid;
  logic [DATA_WIDTH-1:0]    r_rdata;
  logic [1:0]               r_rresp;

  logic            w_aw_hs;
  logic            w_w_hs;
  logic            w_ar_hs;
  logic            w_commit;
  logic            w_wr_legal;
  logic            w_rd_legal;
  logic [IDXW-1:0] w_wr_idx;
  logic [IDXW-1:0] w_rd_idx;

  assign S_AWREADY = ARESETN && !r_aw_full && !r_bvalid;
  assign S_WREADY  = ARESETN && !r_w_full && !r_bvalid;
  assign S_ARREADY = ARESETN && !r_rvalid;
  assign S_BVALID  = r_bvalid;
  assign S_BRESP   = r_bresp;
  assign S_RVALID  = r_rvalid;
  assign S_RDATA   = r_rdata;
  assign S_RRESP   = r_rresp;

  assign w_aw_hs  = S_AWVALID && S_AWREADY;
  assign w_w_hs   = S_WVALID && S_WREADY;
  assign w_ar_hs  = S_ARVALID && S_ARREADY;
  assign w_commit = r_aw_full && r_w_full;

  assign w_wr_legal = (r_aw_addr < LIMIT) && (r_aw_addr[1:0] == 2'b00);
  assign w_rd_legal = (S_ARADDR < LIMIT) && (S_ARADDR[1:0] == 2'b00);
  assign w_wr_idx   = r_aw_addr[IDXW+1:2];
  assign w_rd_idx   = S_ARADDR[IDXW+1:2];

  // Buffer AW and W independently until both halves of a write are held.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_aw_full <= 1'b0;
      r_aw_addr <= '0;
      r_w_full  <= 1'b0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
    end else if (w_commit) begin
      r_aw_full <= 1'b0;
      r_w_full  <= 1'b0;
    end else begin
      if (w_aw_hs) begin
        r_aw_full <= 1'b1;
        r_aw_addr <= S_AWADDR;
      end
      if (w_w_hs) begin
        r_w_full <= 1'b1;
        r_w_data <= S_WDATA;
        r_w_strb <= S_WSTRB;
      end
    end
  end

  // Write response: raised on commit, held until the master takes it.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_bvalid <= 1'b0;
      r_bresp  <= 2'b00;
    end else if (w_commit) begin
      r_bvalid <= 1'b1;
      r_bresp  <= w_wr_legal ? OKAY : BAD_RESP;
    end else if (r_bvalid && S_BREADY) begin
      r_bvalid <= 1'b0;
      r_bresp  <= 2'b00;
    end
  end

  // Register bank: byte-masked update on a legal commit.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_commit && w_wr_legal) begin
      for (int b = 0; b < NSTRB; b++) begin
        if (r_w_strb[b])
          r_regs[w_wr_idx][b*8 +: 8] <= r_w_data[b*8 +: 8];
      end
    end
  end

  // Read channel: sample the bank on AR, hold the beat until R handshake.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= 2'b00;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rd_legal ? r_regs[w_rd_idx] : '0;
      r_rresp  <= w_rd_legal ? OKAY : BAD_RESP;
    end else if (r_rvalid && S_RREADY) begin
      r_rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi4_lite_regfile_slave.sv
// Directed bench for axi4_lite_regfile_slave.
// Expected illegal-address response follows AXI4_LITE_REGFILE_ERR_EN.
module tb_axi4_lite_regfile_slave;

  logic        clk;
  logic        rst_n;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  int total = 0;
  int bad   = 0;

`ifdef AXI4_LITE_REGFILE_ERR_EN
  localparam logic [1:0] EXP_BAD = 2'b10;
`else
  localparam logic [1:0] EXP_BAD = 2'b00;
`endif

  axi4_lite_regfile_slave dut (
    .ACLK      (clk),
    .ARESETN   (rst_n),
    .S_AWADDR  (awaddr),
    .S_AWVALID (awvalid),
    .S_AWREADY (awready),
    .S_WDATA   (wdata),
    .S_WSTRB   (wstrb),
    .S_WVALID  (wvalid),
    .S_WREADY  (wready),
    .S_BRESP   (bresp),
    .S_BVALID  (bvalid),
    .S_BREADY  (bready),
    .S_ARADDR  (araddr),
    .S_ARVALID (arvalid),
    .S_ARREADY (arready),
    .S_RDATA   (rdata),
    .S_RRESP   (rresp),
    .S_RVALID  (rvalid),
    .S_RREADY  (rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // AW and W together; checks B arrives one cycle after the handshake.
  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s, input logic [1:0] eresp,
                    input string tag);
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1;
    chk({tag, ".awready"}, 32'(awready), 32'd1);
    chk({tag, ".wready"}, 32'(wready), 32'd1);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    chk({tag, ".b_early"}, 32'(bvalid), 32'd0);
    @(negedge clk);
    chk({tag, ".bvalid"}, 32'(bvalid), 32'd1);
    chk({tag, ".bresp"}, 32'(bresp), 32'(eresp));
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk({tag, ".b_clr"}, 32'(bvalid), 32'd0);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] ed,
                    input logic [1:0] eresp, input string tag);
    @(negedge clk);
    araddr = a; arvalid = 1'b1;
    chk({tag, ".arready"}, 32'(arready), 32'd1);
    @(negedge clk);
    arvalid = 1'b0;
    chk({tag, ".rvalid"}, 32'(rvalid), 32'd1);
    chk({tag, ".rdata"}, rdata, ed);
    chk({tag, ".rresp"}, 32'(rresp), 32'(eresp));
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    chk({tag, ".r_clr"}, 32'(rvalid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    awaddr = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b0;
    araddr = '0; arvalid = 1'b0;
    rready = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst.awready", 32'(awready), 32'd0);
    chk("rst.wready", 32'(wready), 32'd0);
    chk("rst.arready", 32'(arready), 32'd0);
    chk("rst.bvalid", 32'(bvalid), 32'd0);
    chk("rst.rvalid", 32'(rvalid), 32'd0);
    chk("rst.rdata", rdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post.awready", 32'(awready), 32'd1);
    chk("post.arready", 32'(arready), 32'd1);

    // same-cycle AW/W then readback
    wr(32'h8, 32'hDEADBEEF, 4'hF, 2'b00, "w8");
    rd(32'h8, 32'hDEADBEEF, 2'b00, "r8");

    // W three cycles ahead of AW, partial strobe
    wr(32'h4, 32'hFFFFFFFF, 4'hF, 2'b00, "w4a");
    @(negedge clk);
    wdata = 32'h12345678; wstrb = 4'b0101; wvalid = 1'b1;
    chk("wfirst.wready", 32'(wready), 32'd1);
    @(negedge clk);
    wvalid = 1'b0;
    chk("wfirst.wready_drop", 32'(wready), 32'd0);
    chk("wfirst.awready", 32'(awready), 32'd1);
    @(negedge clk);
    chk("wfirst.nob1", 32'(bvalid), 32'd0);
    @(negedge clk);
    chk("wfirst.nob2", 32'(bvalid), 32'd0);
    awaddr = 32'h4; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    chk("wfirst.b_early", 32'(bvalid), 32'd0);
    @(negedge clk);
    chk("wfirst.bvalid", 32'(bvalid), 32'd1);
    chk("wfirst.bresp", 32'(bresp), 32'd0);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk("wfirst.b_clr", 32'(bvalid), 32'd0);
    @(negedge clk);
    chk("wfirst.one_b", 32'(bvalid), 32'd0);
    rd(32'h4, 32'hFF34FF78, 2'b00, "r4");

    // B backpressure for 5 cycles, second write queued behind it
    @(negedge clk);
    awaddr = 32'h10; wdata = 32'hCAFEF00D; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    awaddr = 32'h14; wdata = 32'h00000011;
    @(negedge clk);
    chk("bp.bvalid0", 32'(bvalid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp.bvalid", 32'(bvalid), 32'd1);
      chk("bp.bresp", 32'(bresp), 32'd0);
      chk("bp.awready", 32'(awready), 32'd0);
      chk("bp.wready", 32'(wready), 32'd0);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk("bp.b_clr", 32'(bvalid), 32'd0);
    chk("bp.awready_back", 32'(awready), 32'd1);
    chk("bp.wready_back", 32'(wready), 32'd1);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    chk("bp2.b_early", 32'(bvalid), 32'd0);
    @(negedge clk);
    chk("bp2.bvalid", 32'(bvalid), 32'd1);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    rd(32'h10, 32'hCAFEF00D, 2'b00, "r10");
    rd(32'h14, 32'h00000011, 2'b00, "r14");

    // illegal addresses
    rd(32'h40, 32'h0, EXP_BAD, "r40");
    wr(32'h2, 32'hBAD0BAD0, 4'hF, EXP_BAD, "w2");
    rd(32'h0, 32'h0, 2'b00, "r0");
    rd(32'h8, 32'hDEADBEEF, 2'b00, "r8b");
    rd(32'h4, 32'hFF34FF78, 2'b00, "r4b");

    // AR on the same edge as a commit to 0xC
    @(negedge clk);
    awaddr = 32'hC; wdata = 32'hA5A5A5A5; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 32'hC; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    chk("same.bvalid", 32'(bvalid), 32'd1);
    chk("same.rvalid", 32'(rvalid), 32'd1);
    chk("same.rdata", rdata, 32'h0);
    bready = 1'b1; rready = 1'b1;
    @(negedge clk);
    bready = 1'b0; rready = 1'b0;
    rd(32'hC, 32'hA5A5A5A5, 2'b00, "rC");

    // reset with R pending and a write half-captured
    @(negedge clk);
    araddr = 32'h8; arvalid = 1'b1;
    wdata = 32'h55555555; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0; wvalid = 1'b0;
    chk("mid.rvalid", 32'(rvalid), 32'd1);
    chk("mid.wready", 32'(wready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid.rvalid_rst", 32'(rvalid), 32'd0);
    chk("mid.bvalid_rst", 32'(bvalid), 32'd0);
    chk("mid.arready_rst", 32'(arready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    awaddr = 32'h8; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    @(negedge clk);
    chk("mid.no_stale_b", 32'(bvalid), 32'd0);
    chk("mid.wready_after", 32'(wready), 32'd1);
    for (int i = 0; i < 16; i++)
      rd(32'(i * 4), 32'h0, 2'b00, "zero");
    // complete the pending AW so the bench leaves the bus idle
    @(negedge clk);
    wdata = 32'h1; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    @(negedge clk);
    chk("tail.bvalid", 32'(bvalid), 32'd1);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    rd(32'h8, 32'h1, 2'b00, "tail.r8");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
